// File: rtl/ext_mem_if.sv
// Handshake/address bus between an external-memory initiator and a responder.
// The data byte lives outside the interface as a plain inout net.
interface ext_mem_if;
  logic [15:0] ext_mem_addr;
  logic        ext_mem_read;
  logic        ext_mem_write;
  logic        ext_mem_cs;
  logic        ext_mem_ready;

  modport master (
    output ext_mem_addr, ext_mem_read, ext_mem_write, ext_mem_cs,
    input  ext_mem_ready
  );

  modport slave (
    input  ext_mem_addr, ext_mem_read, ext_mem_write, ext_mem_cs,
    output ext_mem_ready
  );
endinterface

// File: rtl/ext_mem_responder.sv
// Wait-state external memory responder backed by a 2^MEM_AW byte RAM window at BASE_ADDR.
// Define EXT_MEM_RESP_STATS_EN to build the rd_count/wr_count transaction counters.
module ext_mem_responder #(
  parameter logic [15:0] BASE_ADDR   = 16'h0000,
  parameter int          MEM_AW      = 12,
  parameter int          WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  ext_mem_if.slave    bus,
  inout  wire  [7:0]  ext_mem_data,
  output logic        bus_error,
  output logic [15:0] rd_count,
  output logic [15:0] wr_count
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_ACCESS = 2'd2,
    ST_HOLD   = 2'd3
  } state_t;

  // 17-bit bounds so a window touching 16'hFFFF does not wrap into low addresses
  localparam logic [16:0] WIN_LO = {1'b0, BASE_ADDR};
  localparam logic [16:0] WIN_HI = WIN_LO + (17'd1 << MEM_AW);

  state_t              state_r, state_nx_s;
  logic [3:0]          cnt_r, cnt_nx_s;
  logic [MEM_AW-1:0]   addr_r;
  logic                is_read_r;
  logic                ready_r;
  logic                bus_error_r;
  logic [7:0]          rdata_r;
  logic [7:0]          mem_r [2**MEM_AW];

  logic [16:0]         addr17_s;
  logic [15:0]         off_s;
  logic                hit_s, req_ok_s, both_s, latch_s, access_done_s, abort_s;

  assign addr17_s = {1'b0, bus.ext_mem_addr};
  assign off_s    = bus.ext_mem_addr - BASE_ADDR;
  assign hit_s    = bus.ext_mem_cs && (addr17_s >= WIN_LO) && (addr17_s < WIN_HI);
  assign req_ok_s = hit_s && (bus.ext_mem_read ^ bus.ext_mem_write);
  assign both_s   = hit_s && bus.ext_mem_read && bus.ext_mem_write && (state_r == ST_IDLE);
  assign abort_s  = !bus.ext_mem_cs || (is_read_r ? !bus.ext_mem_read : !bus.ext_mem_write);

  // Next-state, wait-counter and latch-enable decode
  always_comb begin
    state_nx_s    = state_r;
    cnt_nx_s      = cnt_r;
    latch_s       = 1'b0;
    access_done_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (req_ok_s) begin
          latch_s = 1'b1;
          if (WAIT_CYCLES > 0) begin
            state_nx_s = ST_WAIT;
            cnt_nx_s   = 4'(WAIT_CYCLES);
          end else begin
            state_nx_s = ST_ACCESS;
          end
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (abort_s) begin
          state_nx_s = ST_IDLE;
          cnt_nx_s   = 4'd0;
        end else if (cnt_r == 4'd1) begin
          state_nx_s = ST_ACCESS;
          cnt_nx_s   = 4'd0;
        end else begin
          cnt_nx_s   = cnt_r - 4'd1;
        end
      end
      ST_ACCESS: begin
        access_done_s = 1'b1;
        state_nx_s    = ST_HOLD;
      end
      ST_HOLD: begin
        if (!bus.ext_mem_cs || (!bus.ext_mem_read && !bus.ext_mem_write)) begin
          state_nx_s = ST_IDLE;
        end else begin
          state_nx_s = ST_HOLD;
        end
      end
      default: begin
        state_nx_s = ST_IDLE;
        cnt_nx_s   = 4'd0;
      end
    endcase
  end

  // Control state, latched request and the registered ready/error outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      cnt_r       <= 4'd0;
      addr_r      <= '0;
      is_read_r   <= 1'b0;
      ready_r     <= 1'b0;
      bus_error_r <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      cnt_r   <= cnt_nx_s;
      ready_r <= access_done_s;
      if (latch_s) begin
        addr_r    <= off_s[MEM_AW-1:0];
        is_read_r <= bus.ext_mem_read;
      end
      if (both_s) begin
        bus_error_r <= 1'b1;
      end
    end
  end

  // RAM array and read register; never reset so contents survive rst_n
  always_ff @(posedge clk) begin
    if (access_done_s && !is_read_r) begin
      mem_r[addr_r] <= ext_mem_data;
    end
    if (access_done_s && is_read_r) begin
      rdata_r <= mem_r[addr_r];
    end
  end

  assign ext_mem_data      = (ready_r && is_read_r && bus.ext_mem_read) ? rdata_r : 8'hzz;
  assign bus.ext_mem_ready = ready_r;
  assign bus_error         = bus_error_r;

`ifdef EXT_MEM_RESP_STATS_EN
  logic [15:0] rd_cnt_r, wr_cnt_r;

  // Completed-transaction counters, wrapping at 16 bits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_cnt_r <= 16'h0000;
      wr_cnt_r <= 16'h0000;
    end else if (access_done_s) begin
      if (is_read_r) begin
        rd_cnt_r <= rd_cnt_r + 16'd1;
      end else begin
        wr_cnt_r <= wr_cnt_r + 16'd1;
      end
    end
  end

  assign rd_count = rd_cnt_r;
  assign wr_count = wr_cnt_r;
`else
  assign rd_count = 16'h0000;
  assign wr_count = 16'h0000;
`endif

endmodule

// File: tb/tb_ext_mem_responder.sv
// Scoreboard bench: three responders (WAIT_CYCLES 0, 3, 5) at BASE_ADDR 16'h1000.
// Stimulus pushes expected ready cycle/data; a negedge monitor pops and compares.
module tb_ext_mem_responder;

  typedef struct {
    int         cyc;
    bit         is_rd;
    logic [7:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_pass = 0;
  int   n_total = 0;

  logic [15:0] t_addr [3];
  logic        t_rd [3], t_wr [3], t_cs [3], t_den [3];
  logic [7:0]  t_dout [3];
  logic        rdy [3], rdy_d [3], berr [3];
  logic [7:0]  dseen [3];
  logic [15:0] rdc [3], wrc [3];
  int          m_rd [3], m_wr [3];
  exp_t        sbq [3][$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int wc(input int k);
    return (k == 0) ? 0 : (k == 1) ? 3 : 5;
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    ext_mem_if bus ();
    tri1 [7:0] dbus;
    assign bus.ext_mem_addr  = t_addr[g];
    assign bus.ext_mem_read  = t_rd[g];
    assign bus.ext_mem_write = t_wr[g];
    assign bus.ext_mem_cs    = t_cs[g];
    assign dbus      = t_den[g] ? t_dout[g] : 8'hzz;
    assign rdy[g]    = bus.ext_mem_ready;
    assign dseen[g]  = dbus;
    ext_mem_responder #(
      .BASE_ADDR  (16'h1000),
      .MEM_AW     (12),
      .WAIT_CYCLES((g == 0) ? 0 : (g == 1) ? 3 : 5)
    ) u_dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .bus         (bus.slave),
      .ext_mem_data(dbus),
      .bus_error   (berr[g]),
      .rd_count    (rdc[g]),
      .wr_count    (wrc[g])
    );
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic logic [15:0] exp_cnt(input int model);
`ifdef EXT_MEM_RESP_STATS_EN
    return 16'(model);
`else
    return 16'h0000;
`endif
  endfunction

  // Monitor: every ready pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      if (rst_n && rdy[i]) begin
        if (sbq[i].size() == 0) begin
          n_total++;
          $display("FAIL unexpected_ready: inst %0d got ready at cycle %0d, expected none", i, cyc);
        end else begin
          e = sbq[i].pop_front();
          check($sformatf("ready_cycle_i%0d", i), 32'(cyc), 32'(e.cyc));
          if (e.is_rd) check($sformatf("read_data_i%0d", i), {24'h0, dseen[i]}, {24'h0, e.data});
        end
      end
      if (rst_n && rdy_d[i] && !rdy[i] && !t_den[i])
        check($sformatf("bus_release_i%0d", i), {24'h0, dseen[i]}, 32'h0000_00FF);
      rdy_d[i] = rdy[i];
    end
  end

  // One request: drive, optionally expect a response, keep strobes for hold edges, then release
  task automatic access(input int k, input bit rd, input bit wr, input logic [15:0] addr,
                        input logic [7:0] wdata, input bit exp_resp, input logic [7:0] exp_rdata,
                        input int hold);
    @(posedge clk); #1;
    t_addr[k] = addr; t_cs[k] = 1'b1; t_rd[k] = rd; t_wr[k] = wr;
    t_den[k] = wr && !rd; t_dout[k] = wdata;
    if (exp_resp) begin
      sbq[k].push_back('{cyc + wc(k) + 2, rd, exp_rdata});
      if (rd) m_rd[k]++; else m_wr[k]++;
    end
    repeat (hold) @(posedge clk);
    #1;
    t_cs[k] = 1'b0; t_rd[k] = 1'b0; t_wr[k] = 1'b0; t_den[k] = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  function automatic int hn(input int k, input int extra);
    return wc(k) + 3 + extra;
  endfunction

  initial begin
    for (int i = 0; i < 3; i++) begin
      t_addr[i] = 16'h0000; t_rd[i] = 1'b0; t_wr[i] = 1'b0; t_cs[i] = 1'b0;
      t_den[i] = 1'b0; t_dout[i] = 8'h00; rdy_d[i] = 1'b0; m_rd[i] = 0; m_wr[i] = 0;
    end
    #12;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("reset_ready_i%0d", i), 32'(rdy[i]), 32'd0);
      check($sformatf("reset_berr_i%0d", i), 32'(berr[i]), 32'd0);
      check($sformatf("reset_data_z_i%0d", i), {24'h0, dseen[i]}, 32'h0000_00FF);
    end
    @(posedge clk); #1 rst_n = 1'b1;

    // zero-wait write then read back
    access(0, 1'b0, 1'b1, 16'h1000, 8'h34, 1'b1, 8'h00, hn(0, 0));
    access(0, 1'b1, 1'b0, 16'h1000, 8'h00, 1'b1, 8'h34, hn(0, 0));
    // three writes and two reads with strobes held 4 cycles past ready
    access(0, 1'b0, 1'b1, 16'h1005, 8'h11, 1'b1, 8'h00, hn(0, 4));
    access(0, 1'b0, 1'b1, 16'h1006, 8'h22, 1'b1, 8'h00, hn(0, 4));
    access(0, 1'b0, 1'b1, 16'h1007, 8'h33, 1'b1, 8'h00, hn(0, 4));
    access(0, 1'b1, 1'b0, 16'h1006, 8'h00, 1'b1, 8'h22, hn(0, 4));
    access(0, 1'b1, 1'b0, 16'h1007, 8'h00, 1'b1, 8'h33, hn(0, 4));
    check("wr_count_i0", 32'(wrc[0]), 32'(exp_cnt(4)));
    check("rd_count_i0", 32'(rdc[0]), 32'(exp_cnt(3)));

    // out-of-window read held 20 cycles: bus must stay released
    @(posedge clk); #1;
    t_addr[0] = 16'h8000; t_cs[0] = 1'b1; t_rd[0] = 1'b1;
    repeat (20) begin
      @(negedge clk);
      check("oow_data_z", {24'h0, dseen[0]}, 32'h0000_00FF);
    end
    #1; t_cs[0] = 1'b0; t_rd[0] = 1'b0;
    repeat (2) @(posedge clk);

    // both strobes together: no transaction, sticky error across a good access
    access(0, 1'b1, 1'b1, 16'h1003, 8'h00, 1'b0, 8'h00, 4);
    check("bus_error_set", 32'(berr[0]), 32'd1);
    access(0, 1'b1, 1'b0, 16'h1005, 8'h00, 1'b1, 8'h11, hn(0, 0));
    check("bus_error_sticky", 32'(berr[0]), 32'd1);

    // three-wait read of a preloaded zero, plus window edges
    access(1, 1'b0, 1'b1, 16'h1001, 8'h00, 1'b1, 8'h00, hn(1, 0));
    access(1, 1'b1, 1'b0, 16'h1001, 8'h00, 1'b1, 8'h00, hn(1, 0));
    access(1, 1'b0, 1'b1, 16'h1FFF, 8'h5A, 1'b1, 8'h00, hn(1, 0));
    access(1, 1'b1, 1'b0, 16'h1FFF, 8'h00, 1'b1, 8'h5A, hn(1, 0));
    access(1, 1'b0, 1'b1, 16'h0FFF, 8'h77, 1'b0, 8'h00, hn(1, 2));
    access(1, 1'b0, 1'b1, 16'h2000, 8'h77, 1'b0, 8'h00, hn(1, 2));

    // five-wait write aborted by cs drop: prior value kept, no count
    access(2, 1'b0, 1'b1, 16'h1002, 8'h00, 1'b1, 8'h00, hn(2, 0));
    access(2, 1'b0, 1'b1, 16'h1002, 8'hFF, 1'b0, 8'h00, 2);
    access(2, 1'b1, 1'b0, 16'h1002, 8'h00, 1'b1, 8'h00, hn(2, 0));
    check("wr_count_abort_i2", 32'(wrc[2]), 32'(exp_cnt(1)));
    check("rd_count_i2", 32'(rdc[2]), 32'(exp_cnt(1)));

    // reset mid-WAIT: write dropped, counters and error cleared, RAM retained
    access(2, 1'b0, 1'b1, 16'h1004, 8'h11, 1'b1, 8'h00, hn(2, 0));
    @(posedge clk); #1;
    t_addr[2] = 16'h1004; t_cs[2] = 1'b1; t_wr[2] = 1'b1; t_den[2] = 1'b1; t_dout[2] = 8'h77;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("rst_ready_i%0d", i), 32'(rdy[i]), 32'd0);
      check($sformatf("rst_berr_i%0d", i), 32'(berr[i]), 32'd0);
      check($sformatf("rst_rdcnt_i%0d", i), 32'(rdc[i]), 32'd0);
      check($sformatf("rst_wrcnt_i%0d", i), 32'(wrc[i]), 32'd0);
      m_rd[i] = 0; m_wr[i] = 0;
    end
    t_cs[2] = 1'b0; t_wr[2] = 1'b0; t_den[2] = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    access(2, 1'b1, 1'b0, 16'h1004, 8'h00, 1'b1, 8'h11, hn(2, 0));
    access(0, 1'b1, 1'b0, 16'h1000, 8'h00, 1'b1, 8'h34, hn(0, 0));
    check("rd_count_post_rst_i0", 32'(rdc[0]), 32'(exp_cnt(1)));
    check("wr_count_post_rst_i2", 32'(wrc[2]), 32'(exp_cnt(0)));

    repeat (4) @(posedge clk);
    for (int i = 0; i < 3; i++)
      check($sformatf("scoreboard_empty_i%0d", i), 32'(sbq[i].size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ext_mem_responder.md
EXT_MEM_RESPONDER -- requirements
Module: ext_mem_responder

Interface
REQ-001 Parameter BASE_ADDR, default 16'h0000: first byte address decoded by this block.
REQ-002 Parameter MEM_AW, default 12: internal RAM address width; RAM is 2^MEM_AW bytes.
REQ-003 Parameter WAIT_CYCLES, default 0, range 0-15: extra wait cycles inserted before ready.
REQ-004 clk  input  1  system clock; all state changes on rising edge.
REQ-005 rst_n  input  1  reset; asynchronous assert, active-low.
REQ-006 ext_mem_addr  input  16  byte address from initiator.
REQ-007 ext_mem_data  inout  8  bidirectional data; block drives only during its read ready cycle, else Z.
REQ-008 ext_mem_read  input  1  read strobe.
REQ-009 ext_mem_write  input  1  write strobe.
REQ-010 ext_mem_cs  input  1  chip select.
REQ-011 ext_mem_ready  output  1  one-cycle completion pulse.
REQ-012 bus_error  output  1  sticky flag: read and write strobes seen together.
REQ-013 rd_count  output  16  completed reads (stats build only).
REQ-014 wr_count  output  16  completed writes (stats build only).

Function
REQ-015 Hit = ext_mem_cs AND address within BASE_ADDR .. BASE_ADDR+2^MEM_AW-1; RAM index = ext_mem_addr - BASE_ADDR, low MEM_AW bits.
REQ-016 States: IDLE, WAIT, ACCESS, HOLD.
REQ-017 IDLE: on edge sampling hit AND exactly one strobe, latch address and direction; go to WAIT if WAIT_CYCLES>0, else ACCESS.
REQ-018 WAIT: down-counter loaded with WAIT_CYCLES; go to ACCESS on edge it reaches 1.
REQ-019 ACCESS: ext_mem_ready rises exactly WAIT_CYCLES+1 edges after sampling edge; held high one cycle only.
REQ-020 Write: RAM byte written with ext_mem_data sampled on the edge ready rises.
REQ-021 Read: RAM byte registered on the edge ready rises; driven on ext_mem_data while ext_mem_ready AND ext_mem_read.
REQ-022 After ready pulse go to HOLD; stay until ext_mem_cs low or both strobes low, then IDLE; a held request SHALL NOT be serviced twice.
REQ-023 Abort: cs low or latched strobe dropped during WAIT -> IDLE next edge; no ready, no RAM write, counters unchanged.
REQ-024 Address outside window: ignored in every state; no ready, data stays Z.
REQ-025 Both strobes high while hit in IDLE: no transaction, bus_error set, stays set until reset.
REQ-026 Back-to-back: earliest new sampling edge is first edge after HOLD exits to IDLE.

Reset
REQ-027 rst_n low asynchronously: state IDLE, ext_mem_ready 0, ext_mem_data Z, bus_error 0, wait counter 0, rd_count/wr_count 0.
REQ-028 Reset during WAIT or ACCESS aborts transaction; pending write not committed; RAM contents not cleared.
REQ-029 First request sampled on first rising edge after rst_n high.

Configuration
REQ-030 Macro EXT_MEM_RESP_STATS_EN defined: rd_count/wr_count increment by 1 on each ready pulse of the matching direction, wrap FFFF->0000.
REQ-031 EXT_MEM_RESP_STATS_EN undefined: counter logic absent, rd_count and wr_count tied to 16'h0000; all other behaviour identical.

Verification
REQ-032 WAIT_CYCLES=0, BASE_ADDR=16'h1000: write 8'h34 to 16'h1000, then read 16'h1000 -> ready 1 edge after each request, read returns 8'h34.
REQ-033 WAIT_CYCLES=3: read 16'h1001 preloaded 8'h00 -> ready exactly 4 edges after sampling, data 8'h00 only during ready cycle.
REQ-034 Read 16'h8000 (out of window) held 20 cycles -> ready never asserts, ext_mem_data Z throughout.
REQ-035 WAIT_CYCLES=5: write 8'hFF to 16'h1002, drop cs after 2 cycles, then read 16'h1002 -> returns prior value 8'h00, wr_count unchanged.
REQ-036 Assert read and write together at 16'h1003 -> no ready, bus_error 1; held across later good accesses; rst_n pulse clears it.
REQ-037 Stats build: 3 writes, 2 reads, strobes held 4 cycles past ready -> wr_count 3, rd_count 2, exactly one ready pulse per access.
